// File: rtl/risc16_mem_arbiter_pkg.sv
// Shared types and widths for the risc16 unified-SRAM arbiter.
package risc16_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef enum logic [1:0] {GNT_NONE, GNT_D, GNT_I, GNT_H} grant_t;

endpackage

// File: rtl/risc16_mem_arbiter_pick.sv
// Fixed-priority pick (data > fetch > host) with a host starvation override.
module mem_arb_pick
    import risc16_mem_pkg::*;
(
    input  logic   d_req,
    input  logic   i_req,
    input  logic   h_req,
    input  logic   starve,
    output grant_t gnt
);

    always_comb begin
        gnt = GNT_NONE;
        if (h_req && starve) begin
            gnt = GNT_H;
        end else if (d_req) begin
            gnt = GNT_D;
        end else if (i_req) begin
            gnt = GNT_I;
        end else if (h_req) begin
            gnt = GNT_H;
        end
    end

endmodule

// File: rtl/risc16_mem_arbiter.sv
// Three-way arbiter onto one single-ported 16-bit SRAM with programmable wait states.
//  state  | meaning
//  IDLE   | arbitrate, latch winner onto mem_* and load wait counter
//  ACCESS | drive SRAM from latched request, count down wait states
//  RESP   | one-cycle ack to the winner
module risc16_mem_arbiter
    import risc16_mem_pkg::*;
#(
    parameter int WAIT_CYC   = 0,
    parameter int STARVE_LIM = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_req,
    input  logic              d_we0,
    input  logic              d_we1,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              h_req,
    input  logic              h_we0,
    input  logic              h_we1,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din,
    output logic              mem_oe,
    output logic              mem_we0,
    output logic              mem_we1,
    output logic              busy
);

    localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
    localparam logic [3:0]    WAIT_INIT  = 4'(WAIT_CYC);

    state_t        state;
    grant_t        pick_gnt;
    grant_t        lat_gnt;
    logic [3:0]    wait_cnt;
    logic [SW-1:0] starve_cnt;
    logic          starve;

    assign starve = (starve_cnt == STARVE_MAX);
    assign busy   = (state != IDLE);

    mem_arb_pick u_pick (
        .d_req  (d_req),
        .i_req  (i_req),
        .h_req  (h_req),
        .starve (starve),
        .gnt    (pick_gnt)
    );

    // mem_* registers double as the latched copy of the winning request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_gnt    <= GNT_NONE;
            wait_cnt   <= 4'd0;
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_dout   <= '0;
            mem_oe     <= 1'b0;
            mem_we0    <= 1'b0;
            mem_we1    <= 1'b0;
            d_rdata    <= '0;
            i_rdata    <= '0;
            h_rdata    <= '0;
            d_ack      <= 1'b0;
            i_ack      <= 1'b0;
            h_ack      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    lat_gnt  <= pick_gnt;
                    wait_cnt <= WAIT_INIT;
                    case (pick_gnt)
                        GNT_D: begin
                            state    <= ACCESS;
                            mem_addr <= d_addr;
                            mem_dout <= d_wdata;
                            mem_we0  <= d_we0;
                            mem_we1  <= d_we1;
                            mem_oe   <= !(d_we0 || d_we1);
                        end
                        GNT_I: begin
                            state    <= ACCESS;
                            mem_addr <= i_addr;
                            mem_dout <= '0;
                            mem_we0  <= 1'b0;
                            mem_we1  <= 1'b0;
                            mem_oe   <= 1'b1;
                        end
                        GNT_H: begin
                            state    <= ACCESS;
                            mem_addr <= h_addr;
                            mem_dout <= h_wdata;
                            mem_we0  <= h_we0;
                            mem_we1  <= h_we1;
                            mem_oe   <= !(h_we0 || h_we1);
                        end
                        default: ;
                    endcase
                    // Only d/i grants made while the host waits count toward starvation.
                    if (pick_gnt == GNT_H || !h_req) begin
                        starve_cnt <= '0;
                    end else if (pick_gnt != GNT_NONE && !starve) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        state    <= RESP;
                        mem_addr <= '0;
                        mem_dout <= '0;
                        mem_oe   <= 1'b0;
                        mem_we0  <= 1'b0;
                        mem_we1  <= 1'b0;
                        if (mem_oe) begin
                            case (lat_gnt)
                                GNT_D:   d_rdata <= mem_din;
                                GNT_I:   i_rdata <= mem_din;
                                GNT_H:   h_rdata <= mem_din;
                                default: ;
                            endcase
                        end
                        case (lat_gnt)
                            GNT_D:   d_ack <= 1'b1;
                            GNT_I:   i_ack <= 1'b1;
                            GNT_H:   h_ack <= 1'b1;
                            default: ;
                        endcase
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    d_ack <= 1'b0;
                    i_ack <= 1'b0;
                    h_ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// Directed bench: instance 0 has WAIT_CYC=0/STARVE_LIM=2, instance 1 has WAIT_CYC=3/STARVE_LIM=4.
module tb_risc16_mem_arbiter;

    typedef struct {
        int          inst;
        logic [2:0]  who;
        logic        is_rd;
        logic [15:0] rdata;
        int          at;
    } exp_t;

    localparam logic [2:0] W_D = 3'b100;
    localparam logic [2:0] W_I = 3'b010;
    localparam logic [2:0] W_H = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n   [2];
    logic        d_req   [2];
    logic        d_we0   [2];
    logic        d_we1   [2];
    logic [15:0] d_addr  [2];
    logic [15:0] d_wdata [2];
    logic [15:0] d_rdata [2];
    logic        d_ack   [2];
    logic        i_req   [2];
    logic [15:0] i_addr  [2];
    logic [15:0] i_rdata [2];
    logic        i_ack   [2];
    logic        h_req   [2];
    logic        h_we0   [2];
    logic        h_we1   [2];
    logic [15:0] h_addr  [2];
    logic [15:0] h_wdata [2];
    logic [15:0] h_rdata [2];
    logic        h_ack   [2];
    logic [15:0] mem_addr[2];
    logic [15:0] mem_dout[2];
    logic        mem_oe  [2];
    logic        mem_we0 [2];
    logic        mem_we1 [2];
    logic        busy    [2];

    logic [15:0] md [2];
    logic [15:0] mi [2];
    logic [15:0] mh [2];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a ^ 16'hBEFF;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        risc16_mem_arbiter #(
            .WAIT_CYC   ((g == 0) ? 0 : 3),
            .STARVE_LIM ((g == 0) ? 2 : 4)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .d_req    (d_req[g]),
            .d_we0    (d_we0[g]),
            .d_we1    (d_we1[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_rdata  (d_rdata[g]),
            .d_ack    (d_ack[g]),
            .i_req    (i_req[g]),
            .i_addr   (i_addr[g]),
            .i_rdata  (i_rdata[g]),
            .i_ack    (i_ack[g]),
            .h_req    (h_req[g]),
            .h_we0    (h_we0[g]),
            .h_we1    (h_we1[g]),
            .h_addr   (h_addr[g]),
            .h_wdata  (h_wdata[g]),
            .h_rdata  (h_rdata[g]),
            .h_ack    (h_ack[g]),
            .mem_addr (mem_addr[g]),
            .mem_dout (mem_dout[g]),
            .mem_din  (mem_val(mem_addr[g])),
            .mem_oe   (mem_oe[g]),
            .mem_we0  (mem_we0[g]),
            .mem_we1  (mem_we1[g]),
            .busy     (busy[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int inst, input logic [2:0] who, input logic is_rd,
                        input logic [15:0] rdata, input int at);
        exp_t e;
        e.inst = inst; e.who = who; e.is_rd = is_rd; e.rdata = rdata; e.at = at;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_acked(input int k);
        if (d_ack[k]) d_req[k] = 1'b0;
        if (i_ack[k]) i_req[k] = 1'b0;
        if (h_ack[k]) h_req[k] = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            tick(1);
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (d_ack[k] || i_ack[k] || h_ack[k]) begin
                check("ack_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("ack_who_cycle", {16'(k), 13'd0, d_ack[k], i_ack[k], h_ack[k], 32'(cyc)},
                          {16'(e.inst), 13'd0, e.who, 32'(e.at)});
                    if (e.is_rd) begin
                        if (e.who == W_D) md[k] = e.rdata;
                        if (e.who == W_I) mi[k] = e.rdata;
                        if (e.who == W_H) mh[k] = e.rdata;
                    end
                    check("ack_rdata", {16'd0, d_rdata[k], i_rdata[k], h_rdata[k]},
                          {16'd0, md[k], mi[k], mh[k]});
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            d_req[k] = 1'b0; d_we0[k] = 1'b0; d_we1[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
            i_req[k] = 1'b0; i_addr[k] = '0;
            h_req[k] = 1'b0; h_we0[k] = 1'b0; h_we1[k] = 1'b0; h_addr[k] = '0; h_wdata[k] = '0;
            md[k] = '0; mi[k] = '0; mh[k] = '0;
        end
        #23;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        tick(1);
        for (int k = 0; k < 2; k++) begin
            check("reset_state",
                  {d_rdata[k], i_rdata[k], h_rdata[k], 8'd0, d_ack[k], i_ack[k], h_ack[k],
                   mem_oe[k], mem_we0[k], mem_we1[k], busy[k], 1'b0},
                  64'd0);
            check("reset_mem", {32'd0, mem_addr[k], mem_dout[k]}, 64'd0);
        end

        // 1: single read, zero wait states
        c = cyc;
        d_req[0] = 1'b1; d_addr[0] = 16'h0010;
        push(0, W_D, 1'b1, 16'hBEEF, c + 2);
        tick(1);
        check("t1_access", {mem_oe[0], mem_we0[0], mem_we1[0], busy[0], mem_addr[0]},
              {4'b1001, 16'h0010});
        tick(1);
        d_req[0] = 1'b0;
        check("t1_resp", {mem_oe[0], busy[0], mem_addr[0]}, {2'b01, 16'h0000});
        tick(1);
        check("t1_idle", 64'(busy[0]), 64'd0);
        drain("t1_drain");

        // 2: host low-byte write, three wait states
        c = cyc;
        h_req[1] = 1'b1; h_we0[1] = 1'b1; h_we1[1] = 1'b0;
        h_addr[1] = 16'h0200; h_wdata[1] = 16'h1234;
        push(1, W_H, 1'b0, 16'h0000, c + 5);
        for (int j = 0; j < 4; j++) begin
            tick(1);
            check("t2_access", {mem_oe[1], mem_we0[1], mem_we1[1], mem_addr[1], mem_dout[1]},
                  {3'b010, 16'h0200, 16'h1234});
        end
        tick(1);
        h_req[1] = 1'b0; h_we0[1] = 1'b0;
        check("t2_resp", {mem_oe[1], mem_we0[1], mem_we1[1], mem_addr[1], mem_dout[1]}, 64'd0);
        drain("t2_drain");

        // 3: all three at once -> d, i, h
        c = cyc;
        d_req[0] = 1'b1; d_addr[0] = 16'h0100;
        i_req[0] = 1'b1; i_addr[0] = 16'h0200;
        h_req[0] = 1'b1; h_addr[0] = 16'h0300;
        push(0, W_D, 1'b1, mem_val(16'h0100), c + 2);
        push(0, W_I, 1'b1, mem_val(16'h0200), c + 5);
        push(0, W_H, 1'b1, mem_val(16'h0300), c + 8);
        for (int j = 1; j <= 9; j++) begin
            tick(1);
            release_acked(0);
            check("t3_busy", 64'(busy[0]), 64'((j % 3) != 0));
        end
        drain("t3_drain");

        // 4: host starvation guard with STARVE_LIM=2
        c = cyc;
        d_req[0] = 1'b1; d_addr[0] = 16'h0400;
        h_req[0] = 1'b1; h_addr[0] = 16'h0500;
        for (int n = 0; n < 6; n++) begin
            if (n % 3 == 2) push(0, W_H, 1'b1, mem_val(16'h0500), c + 2 + 3 * n);
            else            push(0, W_D, 1'b1, mem_val(16'h0400), c + 2 + 3 * n);
        end
        tick(17);
        d_req[0] = 1'b0;
        h_req[0] = 1'b0;
        tick(2);
        check("t4_idle", 64'(busy[0]), 64'd0);
        drain("t4_drain");

        // 5: reset in the second ACCESS cycle, then reissue
        c = cyc;
        d_req[1] = 1'b1; d_addr[1] = 16'h0600;
        tick(2);
        check("t5_pre_reset", {mem_oe[1], busy[1], mem_addr[1]}, {2'b11, 16'h0600});
        rst_n[1] = 1'b0;
        d_req[1] = 1'b0;
        #1;
        md[1] = '0; mi[1] = '0; mh[1] = '0;
        check("t5_in_reset", {mem_oe[1], mem_we0[1], mem_we1[1], busy[1], d_ack[1], mem_addr[1]},
              64'd0);
        @(negedge clk);
        #2;
        rst_n[1] = 1'b1;
        tick(6);
        check("t5_idle_after", 64'(busy[1]), 64'd0);
        c = cyc;
        d_req[1] = 1'b1;
        push(1, W_D, 1'b1, mem_val(16'h0600), c + 5);
        tick(5);
        release_acked(1);
        check("t5_reissue_req_dropped", 64'(d_req[1]), 64'd0);
        drain("t5_drain");

        // 6: d_req held one cycle past ack -> second identical access
        c = cyc;
        d_req[0] = 1'b1; d_addr[0] = 16'h0700;
        push(0, W_D, 1'b1, mem_val(16'h0700), c + 2);
        push(0, W_D, 1'b1, mem_val(16'h0700), c + 5);
        tick(4);
        d_req[0] = 1'b0;
        tick(3);
        check("t6_no_third", 64'(busy[0]), 64'd0);
        drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc16_mem_arbiter.md
Name: risc16_mem_arbiter

Overview:
Shares one single-ported 16-bit unified SRAM between three requesters: the CPU data port, the CPU instruction fetch, and a host/DMA loader. It arbitrates by fixed priority (data > fetch > host), with a starvation guard for the host. It sequences each access through a programmable number of memory wait states and returns read data with a one-cycle acknowledge. It sits between the risc16ba core's memory ports and the board SRAM.

Parameters:
WAIT_CYC, 0, extra cycles the SRAM needs beyond one access cycle (0..15).
STARVE_LIM, 4, consecutive non-host grants allowed while h_req is pending before the host is forced to win.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active-low
d_req  in  1  data request, held until d_ack
d_we0  in  1  data low-byte write enable; read when d_we0=d_we1=0
d_we1  in  1  data high-byte write enable
d_addr  in  16  data byte address
d_wdata  in  16  data write value
d_rdata  out  16  data read value, valid when d_ack=1
d_ack  out  1  data access complete, one-cycle pulse
i_req  in  1  fetch request (read only), held until i_ack
i_addr  in  16  fetch address
i_rdata  out  16  fetched word, valid when i_ack=1
i_ack  out  1  fetch complete pulse
h_req  in  1  host request, held until h_ack
h_we0  in  1  host low-byte write enable
h_we1  in  1  host high-byte write enable
h_addr  in  16  host address
h_wdata  in  16  host write value
h_rdata  out  16  host read value, valid when h_ack=1
h_ack  out  1  host access complete pulse
mem_addr  out  16  SRAM address
mem_dout  out  16  SRAM write data
mem_din  in  16  SRAM read data
mem_oe  out  1  SRAM output enable (read)
mem_we0  out  1  SRAM low-byte write strobe
mem_we1  out  1  SRAM high-byte write strobe
busy  out  1  high in any state other than IDLE

Behaviour:
- States:
  - IDLE: arbitrate among requests sampled this cycle; on any request, latch the winner's addr, wdata and we bits, go to ACCESS, load wait counter with WAIT_CYC.
  - ACCESS: mem_* driven from the latched request. If counter=0, capture mem_din and go to RESP; else decrement.
  - RESP: the winner's ack=1 for exactly one cycle; go to IDLE.
- Read: latched we0=we1=0 -> mem_oe=1 throughout ACCESS.
- Write: mem_oe=0; mem_we0/mem_we1 equal the latched we bits throughout ACCESS.
- Fetch is always a read.
- All mem_* are registered. Outside ACCESS: mem_oe=mem_we0=mem_we1=0, mem_addr and mem_dout hold 0.
- Latency from request seen in IDLE to ack: WAIT_CYC+2 cycles. Throughput: one access per WAIT_CYC+3 cycles.
- Read data is registered into the winner's rdata at the ACCESS->RESP edge. The other rdata outputs hold their previous values. On a write, the winner's rdata is unchanged.
- Requesters must deassert req, or present the next request, at the edge where ack is seen. req asserted in IDLE always starts a new access. Inputs changing during ACCESS are ignored; the latched copy is used.
- Priority in IDLE: d > i > h, except when starve_cnt = STARVE_LIM and h_req=1, in which case host wins.
- starve_cnt:
  - increments, saturating at STARVE_LIM, on each d/i grant while h_req=1;
  - clears on host grant or when h_req=0 in IDLE.
- Simultaneous d_req, i_req, h_req with starve_cnt<STARVE_LIM: data wins; fetch is served in the next IDLE cycle.
- Byte writes: address LSB is ignored by the arbiter; the requester sets the we bits.
- Reset (asynchronous, any state, including mid-ACCESS): state=IDLE; all acks, mem_oe and mem_we* =0; mem_addr, mem_dout, all rdata and starve_cnt =0. An in-flight access is abandoned with no ack; the requester reissues it.

Decomposition:
- Package risc16_mem_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - grant enum {GNT_NONE, GNT_D, GNT_I, GNT_H};
  - width constants for address and data (16).
- One sub-module, mem_arb_pick (combinational): inputs d_req, i_req, h_req and the starve flag; output a grant enum. This keeps the priority and override rule unit-testable.
- FSM, latches and counters stay in risc16_mem_arbiter.

Test Plan:
1. WAIT_CYC=0, d_req read at 0x0010, mem_din=0xBEEF -> mem_oe=1 for 1 cycle with mem_addr=0x0010; d_ack 2 cycles after the request; d_rdata=0xBEEF; i_rdata and h_rdata unchanged.
2. WAIT_CYC=3, h_req write 0x1234 to 0x0200 with we0=1, we1=0 -> mem_we0=1, mem_we1=0, mem_dout=0x1234 for 4 cycles; h_ack pulse 5 cycles after the request; mem_oe=0 throughout.
3. d_req, i_req, h_req asserted together -> grant order d, i, h; each ack is a single cycle and reaches only its requester; busy low only for the IDLE cycles between accesses.
4. STARVE_LIM=2: h_req held while d_req is re-asserted after every ack -> two data grants, then host granted; starve_cnt returns to 0.
5. rst_n pulled low in the 2nd ACCESS cycle (WAIT_CYC=3) -> mem_oe and mem_we* drop immediately; no ack is produced; state is IDLE after release; a reissued request completes normally.
6. Requester keeps d_req high for one cycle after d_ack -> a second identical access is performed, confirming that req is sampled in IDLE.
